core_reg_read_seq: RTL
======================

CORE_REG_READ_SEQ -- requirements
Module: core_reg_read_seq

Sequences up to three operand reads (A, B, C) through the register file's single, registered read port and returns all operands together.

Interface
REQ-001 SHALL have parameter-free ports; types reg_num, word, psr_mode come from the shared core package (core/uarch.sv).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a new operand fetch; sampled only while busy=0.
REQ-005 mode  input  psr_mode  register bank mode for the request, latched on accepted start.
REQ-006 reg_a, reg_b, reg_c  input  reg_num  operand register numbers, latched on accepted start.
REQ-007 use_a, use_b, use_c  input  1  operand-needed mask, latched on accepted start.
REQ-008 flush  input  1  synchronous abort of the current request.
REQ-009 rd_value  input  word  register file read data, valid one cycle after rd_r is presented.
REQ-010 rd_mode  output  psr_mode  bank mode to the register file.
REQ-011 rd_r  output  reg_num  read register number to the register file.
REQ-012 busy  output  1  request in progress; start ignored.
REQ-013 done  output  1  one-cycle pulse, operand values valid.
REQ-014 value_a, value_b, value_c  output  word  captured operands, held until next capture.

Function
REQ-015 States: IDLE, ISSUE, DRAIN; busy=1 in ISSUE and DRAIN.
REQ-016 IDLE + start=1 + flush=0: latch mode/regs/mask; if mask nonzero -> ISSUE, else -> IDLE with done=1 next cycle.
REQ-017 ISSUE: each cycle drive rd_r with lowest-order pending operand (A before B before C), clear its pending bit, record its tag in a one-deep capture pipeline.
REQ-018 Unused operands SHALL cost zero cycles; k used operands take exactly k ISSUE cycles.
REQ-019 ISSUE with last pending bit cleared -> DRAIN; DRAIN -> IDLE unconditionally after one cycle.
REQ-020 Each cycle with a valid capture tag: value_<tag> <= rd_value; other value outputs unchanged.
REQ-021 Latency: start sampled high in cycle 0 -> issues cycles 1..k -> done high and all used values valid in cycle k+2.
REQ-022 Unused operand value outputs SHALL keep their previous contents.
REQ-023 rd_mode SHALL equal latched mode whenever busy=1; rd_r SHALL be 0 when not in ISSUE.
REQ-024 flush=1 in any state: next cycle IDLE, pending mask and capture tag cleared, no done, in-flight capture dropped, value outputs unchanged.
REQ-025 start and flush in same cycle: flush wins, start ignored.
REQ-026 start while busy=1: ignored, no side effects; requester holds start until busy=0.
REQ-027 done and start may coincide: the done cycle is IDLE, so a start then is accepted.

Reset
REQ-028 rst_n low asynchronously forces IDLE, busy=0, done=0, rd_r=0, rd_mode=0, mask and capture tag cleared, value_a/b/c=0.
REQ-029 Reset mid-operation SHALL abandon the request with no done pulse after release.

Structure
REQ-030 The operand tag type (A/B/C/none) and state enum SHALL live in the shared core package beside reg_num and word.
REQ-031 Single module with no sub-module; the pending-operand priority pick is an inline combinational function.

Verification
REQ-032 use=111, regs r1/r2/r3 holding 0x11/0x22/0x33 -> rd_r 1,2,3 in cycles 1-3; done cycle 5; values 0x11/0x22/0x33.
REQ-033 use=101, ra=r4 (0xAA), rc=r7 (0xCC) -> two issue cycles; done cycle 4; value_b unchanged from prior.
REQ-034 use=000 -> busy never asserts; done cycle 1; rd_r stays 0.
REQ-035 flush in cycle 2 of a 3-operand request -> IDLE cycle 3, no done, values unchanged; new start then completes normally.
REQ-036 start held during busy, then done coincident with start -> only second request accepted in done cycle; rst_n pulled low mid-ISSUE -> all outputs zero immediately, no done.

Source files
------------

// File: rtl/core_reg_read_seq_pkg.sv
// core_reg_read_seq_pkg: shared core types for the operand read sequencer.
package core_reg_read_seq_pkg;
  typedef logic [3:0] reg_num;
  typedef logic [31:0] word;
  typedef logic [4:0] psr_mode;
  typedef enum logic [1:0] {TAG_NONE, TAG_A, TAG_B, TAG_C} op_tag_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} seq_state_e;
endpackage

// File: rtl/core_reg_read_seq.sv
// core_reg_read_seq: issues up to three operand reads on one registered
// register-file port and returns the captured operands together.
module core_reg_read_seq
  import core_reg_read_seq_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    start,
  input  psr_mode mode,
  input  reg_num  reg_a,
  input  reg_num  reg_b,
  input  reg_num  reg_c,
  input  logic    use_a,
  input  logic    use_b,
  input  logic    use_c,
  input  logic    flush,
  input  word     rd_value,
  output psr_mode rd_mode,
  output reg_num  rd_r,
  output logic    busy,
  output logic    done,
  output word     value_a,
  output word     value_b,
  output word     value_c
);
  seq_state_e r_state;
  logic [2:0] r_pend;
  reg_num     r_ra, r_rb, r_rc;
  psr_mode    r_mode;
  op_tag_e    r_tag;
  op_tag_e    w_pick;
  logic [2:0] w_pend_next;
  logic [2:0] w_mask;

  function automatic op_tag_e pick(input logic [2:0] p);
    return p[0] ? TAG_A : p[1] ? TAG_B : p[2] ? TAG_C : TAG_NONE;
  endfunction

  always_comb begin
    w_mask      = {use_c, use_b, use_a};
    w_pick      = pick(r_pend);
    w_pend_next = r_pend & (r_pend - 3'd1);
    rd_r        = (r_state != ST_ISSUE) ? '0 :
                  (w_pick == TAG_A) ? r_ra : (w_pick == TAG_B) ? r_rb : r_rc;
  end

  assign busy    = r_state != ST_IDLE;
  assign rd_mode = r_mode;

  // r_tag names the operand whose read data arrives on rd_value this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pend  <= '0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_rc    <= '0;
      r_mode  <= '0;
      r_tag   <= TAG_NONE;
      done    <= 1'b0;
      value_a <= '0;
      value_b <= '0;
      value_c <= '0;
    end else begin
      done  <= 1'b0;
      r_tag <= TAG_NONE;
      if (!flush) begin
        if (r_tag == TAG_A) value_a <= rd_value;
        if (r_tag == TAG_B) value_b <= rd_value;
        if (r_tag == TAG_C) value_c <= rd_value;
      end
      if (flush) begin
        r_state <= ST_IDLE;
        r_pend  <= '0;
      end else begin
        case (r_state)
          ST_IDLE: if (start) begin
            r_ra    <= reg_a;
            r_rb    <= reg_b;
            r_rc    <= reg_c;
            r_mode  <= mode;
            r_pend  <= w_mask;
            r_state <= |w_mask ? ST_ISSUE : ST_IDLE;
            done    <= ~|w_mask;
          end
          ST_ISSUE: begin
            r_pend  <= w_pend_next;
            r_tag   <= w_pick;
            r_state <= |w_pend_next ? ST_ISSUE : ST_DRAIN;
          end
          ST_DRAIN: begin
            r_state <= ST_IDLE;
            done    <= 1'b1;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule
